// File: rtl/ft600_cmd_parser.sv
// ft600_cmd_parser
//   Host command engine behind the FT600 245-mode FIFO bridge. It pops 16-bit
//   command frames from the bridge RX FIFO and runs PING / WRITE / READ on a
//   simple synchronous register bus. Every accepted header is echoed back, and
//   read data is pushed to the bridge TX FIFO.
//
//   Header word: [15:14] sync (2'b10), [13:12] op (00 PING, 01 WRITE,
//                [11:8] start address, [7:0] word count.   10 READ, 11 rsvd)
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   rx_en             1-cycle pop pulse to the bridge RX FIFO
//   rx_out, rx_empty  popped word / pop-failed flag, valid the cycle after rx_en
//   tx_en, tx_in      push strobe and word to the bridge TX FIFO
//   tx_full           bridge TX FIFO full (registered in the bridge, lags a push)
//   reg_wr, reg_rd    register bus strobes
//   reg_addr          register address
//   reg_wdata         register write data
//   reg_rdata         read data, valid one cycle after reg_rd
//   busy              FSM not idle
//   err_count         saturating count of bad headers and mid-frame timeouts
module ft600_cmd_parser #(
  parameter int TIMEOUT = 1024,
  parameter int TX_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_en,
  input  logic [15:0] rx_out,
  input  logic        rx_empty,
  output logic        tx_en,
  output logic [15:0] tx_in,
  input  logic        tx_full,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (TX_GAP < 2) ? 1 : $clog2(TX_GAP + 1);

  localparam logic [1:0] OP_PING  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_RESP_HDR, S_GAP, S_WREQ, S_WDATA, S_WSTB,
    S_RREQ, S_RDATA, S_PUSH
  } state_t;

  state_t        state, state_nxt;
  logic          armed;      // low for the first cycle after reset so no pop fires while outputs must be 0
  logic [1:0]    op;
  logic [3:0]    addr;
  logic [7:0]    cnt;        // words still to transfer
  logic [15:0]   tx_data;    // echo header or captured read data
  logic [15:0]   wdata;
  logic [TW-1:0] to_cnt;     // cycles spent waiting for a write data word
  logic [GW-1:0] gap_cnt;

  logic hdr_ok, gap_done;
  logic hdr_load, wr_take, step, err_inc;

  assign hdr_ok   = (rx_out[15:14] == 2'b10) && (rx_out[13:12] != 2'b11);
  assign gap_done = (gap_cnt == GW'(TX_GAP - 1));

  assign tx_in     = tx_data;
  assign reg_addr  = addr;
  assign reg_wdata = wdata;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_en     = 1'b0;
    tx_en     = 1'b0;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    hdr_load  = 1'b0;
    wr_take   = 1'b0;
    step      = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_IDLE: if (armed) begin
        rx_en     = 1'b1;
        state_nxt = S_HDR;
      end
      S_HDR: begin
        state_nxt = S_IDLE;
        if (!rx_empty) begin
          if (hdr_ok) begin
            hdr_load  = 1'b1;
            state_nxt = S_RESP_HDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_RESP_HDR: if (!tx_full) begin
        tx_en     = 1'b1;
        state_nxt = S_GAP;
      end
      // Shared dispatch after every push: the echo and each read word both land here.
      S_GAP: if (gap_done) begin
        if (op == OP_PING || cnt == 8'd0) state_nxt = S_IDLE;
        else if (op == OP_WRITE)          state_nxt = S_WREQ;
        else                              state_nxt = S_RREQ;
      end
      S_WREQ: begin
        rx_en     = 1'b1;
        state_nxt = S_WDATA;
      end
      S_WDATA: begin
        if (!rx_empty) begin
          wr_take   = 1'b1;
          state_nxt = S_WSTB;
        end else if (to_cnt >= TW'(TIMEOUT - 1)) begin
          err_inc   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WREQ;
        end
      end
      S_WSTB: begin
        reg_wr    = 1'b1;
        step      = 1'b1;
        state_nxt = (cnt == 8'd1) ? S_IDLE : S_WREQ;
      end
      S_RREQ: begin
        reg_rd    = 1'b1;
        state_nxt = S_RDATA;
      end
      S_RDATA: state_nxt = S_PUSH;
      S_PUSH: if (!tx_full) begin
        tx_en     = 1'b1;
        step      = 1'b1;
        state_nxt = S_GAP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      armed     <= 1'b0;
      op        <= 2'b00;
      addr      <= 4'd0;
      cnt       <= 8'd0;
      tx_data   <= 16'd0;
      wdata     <= 16'd0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
      err_count <= 8'd0;
    end else begin
      armed <= 1'b1;
      if (hdr_load) begin
        op      <= rx_out[13:12];
        addr    <= rx_out[11:8];
        cnt     <= rx_out[7:0];
        tx_data <= rx_out;
      end
      if (wr_take)          wdata   <= rx_out;
      if (state == S_RDATA) tx_data <= reg_rdata;
      if (step) begin
        addr <= addr + 4'd1;
        cnt  <= cnt - 8'd1;
      end
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
      to_cnt  <= (state == S_WREQ || state == S_WDATA) ? to_cnt + TW'(1) : '0;
      gap_cnt <= (state == S_GAP && !gap_done) ? gap_cnt + GW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_ft600_cmd_parser.sv
`timescale 1ns/1ps
// Bench for ft600_cmd_parser: a bridge model feeds RX words on request and
// answers register reads; a frame-level model predicts echoes, writes, reads
// and the error count; one monitor compares every push and strobe to it.
module tb_ft600_cmd_parser;
  localparam int TIMEOUT = 1024;
  localparam int TX_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_en, rx_empty, tx_en, tx_full, reg_wr, reg_rd, busy;
  logic [15:0] rx_out, tx_in, reg_wdata, reg_rdata;
  logic [3:0]  reg_addr;
  logic [7:0]  err_count;

  ft600_cmd_parser #(.TIMEOUT(TIMEOUT), .TX_GAP(TX_GAP)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_out(rx_out), .rx_empty(rx_empty),
    .tx_en(tx_en), .tx_in(tx_in), .tx_full(tx_full), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] rx_q[$];
  logic [15:0] stim[$];
  logic [15:0] exp_tx[$];
  logic [19:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [15:0] tx_log[$];
  logic [19:0] wr_log[$];
  logic [15:0] mem[16];     // register file behind the bus
  logic [15:0] mregs[16];   // model's view of the same registers
  int          exp_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Frame-level prediction for one burst of host words.
  task automatic model(input logic [15:0] w[$]);
    int i, n, k;
    logic [15:0] h;
    logic [3:0]  a;
    i = 0;
    while (i < w.size()) begin
      h = w[i];
      i++;
      if (h[15:14] != 2'b10 || h[13:12] == 2'b11) begin
        if (exp_err < 255) exp_err++;
      end else begin
        exp_tx.push_back(h);
        a = h[11:8];
        n = int'(h[7:0]);
        if (h[13:12] == 2'b01) begin
          k = 0;
          while (k < n) begin
            if (i < w.size()) begin
              exp_wr.push_back({a, w[i]});
              mregs[a] = w[i];
              i++; a++; k++;
            end else begin
              if (exp_err < 255) exp_err++;   // burst ran dry mid-frame
              k = n;
            end
          end
        end else if (h[13:12] == 2'b10) begin
          for (int j = 0; j < n; j++) begin
            exp_rd.push_back(a);
            exp_tx.push_back(mregs[a]);
            a++;
          end
        end
      end
    end
  endtask

  task automatic add(input logic [15:0] x);
    stim.push_back(x);
  endtask

  task automatic send();
    model(stim);
    foreach (stim[i]) rx_q.push_back(stim[i]);
    stim.delete();
  endtask

  task automatic drain(input string name, input int settle);
    int c;
    c = 0;
    while ((rx_q.size() + exp_tx.size() + exp_wr.size() + exp_rd.size()) != 0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(name, rx_q.size() + exp_tx.size() + exp_wr.size() + exp_rd.size(), 0);
    repeat (settle) @(negedge clk);
  endtask

  task automatic wait_tx(input string name, input int n);
    int c;
    c = 0;
    while (tx_log.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, tx_log.size() >= n, 1);
  endtask

  // Bridge RX side: a pop seen in one cycle delivers its result the next.
  initial begin
    logic pend;
    pend = 1'b0;
    rx_out = 16'h0;
    rx_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (pend && rx_q.size() != 0) begin
        rx_out = rx_q.pop_front();
        rx_empty = 1'b0;
      end else begin
        rx_out = 16'h0BAD;
        rx_empty = 1'b1;
      end
      pend = rx_en && rst;
    end
  end

  // Register read data is valid only in the cycle after reg_rd.
  initial begin
    logic       pend;
    logic [3:0] a;
    pend = 1'b0;
    a = 4'd0;
    reg_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      reg_rdata = pend ? mem[a] : 16'hDEAD;
      pend = reg_rd && rst;
      a = reg_addr;
    end
  end

  // Compare process.
  initial begin
    int since_tx;
    since_tx = 100;
    forever begin
      @(negedge clk);
      #2;
      if (tx_en) begin
        chk("tx_full_at_push", tx_full, 1'b0);
        chk("tx_gap", since_tx >= TX_GAP, 1);
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_data", tx_in, exp_tx.pop_front());
        tx_log.push_back(tx_in);
        since_tx = 0;
      end else begin
        since_tx++;
      end
      if (reg_wr) begin
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) chk("wr_addr_data", {reg_addr, reg_wdata}, exp_wr.pop_front());
        wr_log.push_back({reg_addr, reg_wdata});
        mem[reg_addr] = reg_wdata;
      end
      if (reg_rd) begin
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rd_addr", reg_addr, exp_rd.pop_front());
      end
      if (reg_wr || reg_rd) chk("wr_rd_excl", reg_wr && reg_rd, 1'b0);
      if (tx_en || rx_en)   chk("tx_rx_excl", tx_en && rx_en, 1'b0);
    end
  end

  initial begin
    int  n0;
    logic b0, b1;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 16'h1000 + 16'(i);
      mregs[i] = 16'h1000 + 16'(i);
    end
    tx_full = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("reset_strobes", {rx_en, tx_en, reg_wr, reg_rd, busy}, 5'b0);
    chk("reset_data", {tx_in, reg_wdata, reg_addr, err_count}, 44'h0);
    @(negedge clk);
    rst = 1'b1;

    // PING
    add(16'h8000);
    send();
    drain("ping_drain", 10);
    chk("ping_echo", tx_log[tx_log.size()-1], 16'h8000);
    chk("ping_no_wr", wr_log.size(), 0);
    @(negedge clk); #2; b0 = busy;
    @(negedge clk); #2; b1 = busy;
    chk("ping_idle", b0 && b1, 1'b0);

    // WRITE with address wrap
    add(16'h9E03); add(16'h1111); add(16'h2222); add(16'h3333);
    send();
    drain("write_drain", 10);
    chk("write_echo", tx_log[tx_log.size()-1], 16'h9E03);
    chk("write_e", wr_log[0], {4'hE, 16'h1111});
    chk("write_f", wr_log[1], {4'hF, 16'h2222});
    chk("write_0", wr_log[2], {4'h0, 16'h3333});

    // Bad headers, then a normal ping
    n0 = tx_log.size();
    add(16'h4000); add(16'hF000);
    send();
    drain("bad_drain", 10);
    chk("bad_no_tx", tx_log.size(), n0);
    chk("bad_err", err_count, 8'd2);
    add(16'h8000);
    send();
    drain("bad_ping_drain", 10);
    chk("bad_ping_echo", tx_log.size(), n0 + 1);

    // READ with backpressure after the echo
    mem[2] = 16'hBEEF; mregs[2] = 16'hBEEF;
    mem[3] = 16'hCAFE; mregs[3] = 16'hCAFE;
    n0 = tx_log.size();
    add(16'hA202);
    send();
    wait_tx("read_echo_seen", n0 + 1);
    tx_full = 1'b1;
    repeat (50) @(negedge clk);
    chk("read_bp_hold", tx_log.size(), n0 + 1);
    tx_full = 1'b0;
    drain("read_drain", 10);
    chk("read_w0", tx_log[n0], 16'hA202);
    chk("read_w1", tx_log[n0+1], 16'hBEEF);
    chk("read_w2", tx_log[n0+2], 16'hCAFE);

    // Mid-frame timeout, then recovery
    n0 = wr_log.size();
    add(16'h9002); add(16'h5555);
    send();
    drain("to_drain", TIMEOUT + 50);
    chk("to_one_wr", wr_log.size(), n0 + 1);
    chk("to_wr_val", wr_log[n0], {4'h0, 16'h5555});
    chk("to_err", err_count, 32'(exp_err));
    chk("to_err_lit", err_count, 8'd3);
    add(16'h8000);
    send();
    drain("to_ping_drain", 10);
    chk("to_ping_echo", tx_log[tx_log.size()-1], 16'h8000);

    // Reset while a read word waits in S_PUSH
    n0 = tx_log.size();
    add(16'hA202);
    send();
    wait_tx("rst_echo_seen", n0 + 1);
    tx_full = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    chk("rst_pending_word", tx_in, 16'hBEEF);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_strobes", {rx_en, tx_en, reg_wr, reg_rd, busy}, 5'b0);
    chk("rst_data", {tx_in, reg_wdata, reg_addr, err_count}, 44'h0);
    exp_tx.delete();
    exp_rd.delete();
    exp_err = 0;
    rst = 1'b1;
    tx_full = 1'b0;
    n0 = tx_log.size();
    add(16'h8000);
    send();
    drain("rst_ping_drain", 20);
    chk("rst_single_echo", tx_log.size(), n0 + 1);
    chk("rst_echo_val", tx_log[tx_log.size()-1], 16'h8000);
    chk("rst_err", err_count, 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft600_cmd_parser.md
Name: ft600_cmd_parser

Overview:
- Host-command engine directly downstream of the FT600 245-mode FIFO bridge; consumes its RX word interface and feeds its TX word interface.
- Parses 16-bit command frames from the host and executes register writes, register reads and pings on a simple synchronous register bus.
- Pushes response frames back toward the host.
- Single clock domain (FPGA `clk`).

Parameters:
- TIMEOUT, 1024, max cycles waiting for a mid-frame RX word before the frame is aborted.
- TX_GAP, 2, idle cycles after each `tx_en` pulse before `tx_full` is trusted again (the bridge's `tx_full` is registered and lags).

Ports:
- `clk`  in  1  FPGA clock.
- `rst`  in  1  synchronous reset, active-low (0 = reset, sampled on posedge `clk`).
- `rx_en`  out  1  pop request to the bridge RX FIFO.
- `rx_out`  in  16  word from the bridge; valid in the cycle after `rx_en` when `rx_empty`=0.
- `rx_empty`  in  1  1 in the cycle after `rx_en` = no word popped.
- `tx_en`  out  1  push `tx_in` to the bridge TX FIFO.
- `tx_in`  out  16  response word.
- `tx_full`  in  1  bridge TX FIFO full.
- `reg_wr`  out  1  register write strobe.
- `reg_rd`  out  1  register read strobe.
- `reg_addr`  out  4  register address.
- `reg_wdata`  out  16  write data.
- `reg_rdata`  in  16  read data; valid exactly 1 cycle after `reg_rd`.
- `busy`  out  1  high whenever not in S_IDLE.
- `err_count`  out  8  saturating protocol-error counter.

Behaviour:
- **Reset** (`rst`=0): all outputs 0, `err_count`=0, state S_IDLE. Reset mid-frame discards the frame; no partial response is sent.
- **Header word fields:**
  - [15:14] sync, must be 2'b10.
  - [13:12] op: 00 PING, 01 WRITE, 10 READ, 11 reserved.
  - [11:8] start address A.
  - [7:0] count N.
- **RX pop protocol:** `rx_en` is a 1-cycle pulse. The result is evaluated the next cycle. If `rx_empty`=1, pulse again the following cycle. At most one `rx_en` per 2 cycles.
- **States:**
  - S_IDLE: pulse `rx_en` -> S_HDR.
  - S_HDR:
    - `rx_empty`=1 -> S_IDLE. No timeout applies in S_IDLE/S_HDR.
    - Bad sync or op=11 -> `err_count`+1 (saturating at 255), word dropped -> S_IDLE.
    - Otherwise latch the header -> S_RESP_HDR.
  - S_RESP_HDR: push the echo header (identical to the received word) -> S_GAP.
  - After S_GAP, dispatch:
    - PING -> S_IDLE.
    - N=0 -> S_IDLE.
    - WRITE -> S_WDATA.
    - READ -> S_RREQ.
  - S_WDATA:
    - Pop words as in the RX pop protocol.
    - Each received word: `reg_wr`=1 for one cycle with `reg_addr`=current address, `reg_wdata`=word.
    - Address increments mod 16 (wraps F->0). Remaining count decrements; at 0 -> S_IDLE.
    - Timeout counter resets on every received word. If it reaches TIMEOUT -> `err_count`+1, abort -> S_IDLE. Remaining words are later treated as headers (resync by sync bits).
  - S_RREQ: `reg_rd`=1 for one cycle -> S_RDATA.
  - S_RDATA: capture `reg_rdata` -> S_PUSH.
  - S_PUSH: when `tx_full`=0, push the captured word -> S_GAP.
    - Address increments mod 16, count decrements.
    - Count 0 after S_GAP -> S_IDLE, else -> S_RREQ.
  - S_GAP: holds TX_GAP cycles with `tx_en`=0.
- **TX rules:**
  - `tx_en` only in a cycle where `tx_full`=0 was sampled. One push, then TX_GAP dead cycles.
  - If `tx_full` stays high, wait indefinitely (no timeout on TX backpressure).
- **Mutual exclusion:** `reg_wr` and `reg_rd` are never high together. `tx_en` and `rx_en` may coincide only in principle; this FSM never does so.
- **Write ordering:** for WRITE, the echo header is pushed before the data words are consumed. The ack therefore confirms frame acceptance, not completion.
- **Frame sizes:** N=255 is legal; the address wraps repeatedly.

Test Plan:
- **PING:** RX word 0x8000 -> `tx_in`=0x8000 pushed once; `reg_wr`/`reg_rd` never assert; return to S_IDLE with `busy`=0.
- **WRITE:** RX 0x9E03, 0x1111, 0x2222, 0x3333 -> echo 0x9E03; `reg_wr` at addr E,F,0 with data 0x1111,0x2222,0x3333.
- **READ with backpressure:** RX 0xA202 with regs 2=0xBEEF, 3=0xCAFE, `tx_full` held 1 for 50 cycles after the echo -> pushes 0xA202, 0xBEEF, 0xCAFE in order, no push while `tx_full`=1, ≥TX_GAP idle cycles between pushes.
- **Bad header:** RX 0x4000 then 0xF000 -> no TX, `err_count`=2; following 0x8000 answered normally.
- **Timeout:** RX 0x9002, 0x5555 then RX empty for TIMEOUT cycles -> one `reg_wr` (addr 0, 0x5555), `err_count`+1, S_IDLE; next valid header processed.
- **Reset:** `rst`=0 during S_PUSH of a READ -> all outputs 0 next cycle; after release, RX 0x8000 -> single echo 0x8000.
